// File: rtl/uart_dbus_master.sv
// Host debug bridge: UART byte frames in, word dBus reads/writes out.
// Replies (ACK, NAK or read data plus status) go back over the UART TX port.
module uart_dbus_master #(
    parameter int CLK_FREQ            = 100000000,
    parameter int WL                  = 32,
    parameter int BYTE_TIMEOUT_CYCLES = 1000000,
    parameter int RSP_TIMEOUT_CYCLES  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          tx_rdy,
    output logic          tx_vld,
    output logic [7:0]    tx_data,
    output logic          dbus_cmd_valid,
    input  logic          dbus_cmd_ready,
    output logic          dbus_cmd_payload_wr,
    output logic [WL-1:0] dbus_cmd_payload_address,
    output logic [WL-1:0] dbus_cmd_payload_data,
    output logic [1:0]    dbus_cmd_payload_size,
    input  logic          dbus_rsp_ready,
    input  logic          dbus_rsp_error,
    input  logic [WL-1:0] dbus_rsp_data,
    output logic          busy,
    output logic          overrun
);

    localparam int NB  = WL / 8;
    localparam int BCW = $clog2(NB) + 1;
    localparam int BTW = $clog2(BYTE_TIMEOUT_CYCLES + 1);
    localparam int RTW = $clog2(RSP_TIMEOUT_CYCLES + 1);
    localparam int TLW = $clog2(NB + 2);
    localparam int QW  = WL + 8;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    if (CLK_FREQ <= 0 || WL % 8 != 0 || WL < 8) begin : g_param_err
        $error("uart_dbus_master: bad CLK_FREQ or WL");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, CMD, RSP, TX
    } state_t;

    state_t         state_q, state_d;
    logic           wr_q, wr_d;
    logic [WL-1:0]  addr_q, addr_d;
    logic [WL-1:0]  data_q, data_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [BTW-1:0] btmo_q, btmo_d;
    logic [RTW-1:0] rtmo_q, rtmo_d;
    logic [QW-1:0]  txq_q, txq_d;
    logic [TLW-1:0] txleft_q, txleft_d;
    logic           armed_q, armed_d;
    logic           overrun_q, overrun_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            bcnt_q    <= '0;
            btmo_q    <= '0;
            rtmo_q    <= '0;
            txq_q     <= '0;
            txleft_q  <= '0;
            armed_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bcnt_q    <= bcnt_d;
            btmo_q    <= btmo_d;
            rtmo_q    <= rtmo_d;
            txq_q     <= txq_d;
            txleft_q  <= txleft_d;
            armed_q   <= armed_d;
            overrun_q <= overrun_d;
        end
    end

    // armed_q: tx_rdy has been seen low since the previous byte pulse
    assign tx_vld = (state_q == TX) && armed_q && tx_rdy;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bcnt_d    = bcnt_q;
        btmo_d    = btmo_q;
        rtmo_d    = rtmo_q;
        txq_d     = txq_q;
        txleft_d  = txleft_q;
        armed_d   = armed_q;
        overrun_d = overrun_q;
        if (!tx_rdy) armed_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    bcnt_d = '0;
                    btmo_d = '0;
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        wr_d    = (rx_data == CMD_W);
                        state_d = ADDR;
                    end else begin
                        txq_d    = {{WL{1'b0}}, NAK};
                        txleft_d = TLW'(1);
                        state_d  = TX;
                    end
                end
            end
            ADDR, WDATA: begin
                if (rx_valid) begin
                    btmo_d = '0;
                    bcnt_d = bcnt_q + BCW'(1);
                    if (state_q == ADDR) addr_d = {rx_data, addr_q[WL-1:8]};
                    else                 data_d = {rx_data, data_q[WL-1:8]};
                    if (bcnt_q == BCW'(NB - 1)) begin
                        bcnt_d  = '0;
                        state_d = (state_q == ADDR && wr_q) ? WDATA : CMD;
                    end
                end else if (btmo_q == BTW'(BYTE_TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                end else begin
                    btmo_d = btmo_q + BTW'(1);
                end
            end
            CMD: begin
                if (dbus_cmd_ready) begin
                    if (wr_q) begin
                        txq_d    = {{WL{1'b0}}, ACK};
                        txleft_d = TLW'(1);
                        state_d  = TX;
                    end else begin
                        rtmo_d  = '0;
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (dbus_rsp_ready) begin
                    txq_d    = {dbus_rsp_error ? NAK : ACK, dbus_rsp_data};
                    txleft_d = TLW'(NB + 1);
                    state_d  = TX;
                end else if (rtmo_q == RTW'(RSP_TIMEOUT_CYCLES - 1)) begin
                    txq_d    = {NAK, {WL{1'b0}}};
                    txleft_d = TLW'(NB + 1);
                    state_d  = TX;
                end else begin
                    rtmo_d = rtmo_q + RTW'(1);
                end
            end
            TX: begin
                if (tx_vld) begin
                    txq_d    = txq_q >> 8;
                    txleft_d = txleft_q - TLW'(1);
                    armed_d  = 1'b0;
                    if (txleft_q == TLW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rx_valid && (state_q == CMD || state_q == RSP || state_q == TX))
            overrun_d = 1'b1;
    end

    assign tx_data                  = txq_q[7:0];
    assign dbus_cmd_valid           = (state_q == CMD);
    assign dbus_cmd_payload_wr      = wr_q;
    assign dbus_cmd_payload_address = addr_q;
    assign dbus_cmd_payload_data    = data_q;
    assign dbus_cmd_payload_size    = 2'b10;
    assign busy                     = (state_q != IDLE);
    assign overrun                  = overrun_q;

endmodule

// File: tb/tb_uart_dbus_master.sv
// Directed bench for uart_dbus_master: write, reads, errors, timeouts, reset.
module tb_uart_dbus_master;

    localparam int BTO = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_rdy;
    logic        tx_vld;
    logic [7:0]  tx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_size;
    logic        rsp_ready;
    logic        rsp_error;
    logic [31:0] rsp_data;
    logic        busy;
    logic        overrun;

    uart_dbus_master #(
        .CLK_FREQ(100000000),
        .WL(32),
        .BYTE_TIMEOUT_CYCLES(BTO),
        .RSP_TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .tx_rdy(tx_rdy),
        .tx_vld(tx_vld),
        .tx_data(tx_data),
        .dbus_cmd_valid(cmd_valid),
        .dbus_cmd_ready(cmd_ready),
        .dbus_cmd_payload_wr(cmd_wr),
        .dbus_cmd_payload_address(cmd_addr),
        .dbus_cmd_payload_data(cmd_data),
        .dbus_cmd_payload_size(cmd_size),
        .dbus_rsp_ready(rsp_ready),
        .dbus_rsp_error(rsp_error),
        .dbus_rsp_data(rsp_data),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int ncheck = 0;
    int npass  = 0;
    int vcyc   = 0;
    logic [7:0]  txq[$];
    logic        hs_wr[$];
    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    logic [1:0]  hs_size[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ncheck++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // dBus monitor
    always @(negedge clk) begin
        if (cmd_valid) vcyc++;
        if (cmd_valid && cmd_ready) begin
            hs_wr.push_back(cmd_wr);
            hs_addr.push_back(cmd_addr);
            hs_data.push_back(cmd_data);
            hs_size.push_back(cmd_size);
        end
    end

    // uart_lite transmitter model: busy for 3 cycles per byte
    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_vld && tx_rdy) begin
                txq.push_back(tx_data);
                @(posedge clk);
                #1 tx_rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_rdy = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a,
                              input logic [31:0] d);
        send_byte(c);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (c == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (txq.size() >= n && !busy) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_txcnt"}, 64'(txq.size()), 64'(n));
    endtask

    task automatic chk_tx(input string tag, input logic [39:0] e, input int n);
        logic [7:0] g;
        for (int i = 0; i < n; i++) begin
            g = (i < txq.size()) ? txq[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), {56'd0, g}, {56'd0, e[8*i +: 8]});
        end
    endtask

    task automatic clear_logs();
        txq.delete();
        hs_wr.delete();
        hs_addr.delete();
        hs_data.delete();
        hs_size.delete();
        vcyc = 0;
    endtask

    initial begin
        logic stable;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        rsp_ready = 1'b0;
        rsp_error = 1'b0;
        rsp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmdv", cmd_valid, 1'b0);
        chk("rst_txv", tx_vld, 1'b0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_addr", cmd_addr, 32'h0);
        chk("rst_ovr", overrun, 1'b0);
        reset = 1'b0;

        // write
        clear_logs();
        cmd_ready = 1'b1;
        send_frame(8'h57, 32'h8000_0000, 32'h0000_000C);
        wait_tx("wr", 1, 200);
        chk("wr_ncmd", 64'(hs_addr.size()), 64'd1);
        if (hs_addr.size() > 0) begin
            chk("wr_wr", hs_wr[0], 1'b1);
            chk("wr_addr", hs_addr[0], 32'h8000_0000);
            chk("wr_data", hs_data[0], 32'h0000_000C);
            chk("wr_size", hs_size[0], 2'b10);
        end
        chk_tx("wr", 40'h06, 1);

        // read with command backpressure
        clear_logs();
        cmd_ready = 1'b0;
        send_frame(8'h52, 32'h0000_0010, 32'h0);
        chk("rd_cmd_rise", cmd_valid, 1'b1);
        stable = 1'b1;
        repeat (5) begin
            if (!cmd_valid || cmd_addr !== 32'h10 || cmd_wr !== 1'b0
                || cmd_size !== 2'b10) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("rd_stable", stable, 1'b1);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        chk("rd_cmd_fall", cmd_valid, 1'b0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        rsp_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        wait_tx("rd", 5, 200);
        chk("rd_vcyc", 64'(vcyc), 64'd6);
        chk("rd_ncmd", 64'(hs_addr.size()), 64'd1);
        if (hs_addr.size() > 0) chk("rd_addr", hs_addr[0], 32'h10);
        chk_tx("rd", 40'h06_DEAD_BEEF, 5);

        // read error, response in the cycle right after the handshake
        clear_logs();
        cmd_ready = 1'b1;
        send_frame(8'h52, 32'h4000_0000, 32'h0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        rsp_error = 1'b1;
        rsp_data  = 32'h1234_5678;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        rsp_error = 1'b0;
        wait_tx("rderr", 5, 200);
        if (hs_addr.size() > 0) chk("rderr_addr", hs_addr[0], 32'h4000_0000);
        chk_tx("rderr", 40'h15_1234_5678, 5);

        // bad command
        clear_logs();
        send_byte(8'h41);
        wait_tx("bad", 1, 100);
        chk_tx("bad", 40'h15, 1);
        chk("bad_ncmd", 64'(hs_addr.size()), 64'd0);

        // response timeout, then a late rsp_ready that must be ignored
        clear_logs();
        send_frame(8'h52, 32'h0000_0020, 32'h0);
        wait_tx("rto", 5, 1300);
        chk_tx("rto", 40'h15_0000_0000, 5);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("late_rsp_busy", busy, 1'b0);
        chk("late_rsp_tx", 64'(txq.size()), 64'd5);

        // inter-byte timeout
        clear_logs();
        send_byte(8'h57);
        send_byte(8'h01);
        chk("bto_busy_mid", busy, 1'b1);
        repeat (BTO + 20) @(posedge clk);
        #1;
        chk("bto_busy", busy, 1'b0);
        chk("bto_ncmd", 64'(hs_addr.size()), 64'd0);
        chk("bto_tx", 64'(txq.size()), 64'd0);
        chk("bto_ovr", overrun, 1'b0);

        // overrun during TX
        clear_logs();
        send_frame(8'h52, 32'h0000_0030, 32'h0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        rsp_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        for (int i = 0; i < 100 && txq.size() < 1; i++) @(posedge clk);
        send_byte(8'hAA);
        chk("ovr_set", overrun, 1'b1);
        wait_tx("ovr", 5, 200);
        chk_tx("ovr", 40'h06_CAFE_F00D, 5);

        // asynchronous reset while a command is pending
        clear_logs();
        cmd_ready = 1'b0;
        send_frame(8'h57, 32'h0000_0008, 32'h1111_1111);
        chk("rstmid_pre", cmd_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_cmdv", cmd_valid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ovr", overrun, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
        cmd_ready = 1'b1;
        send_frame(8'h57, 32'h0000_0004, 32'h1234_5678);
        wait_tx("post", 1, 200);
        chk("post_ncmd", 64'(hs_addr.size()), 64'd1);
        if (hs_addr.size() > 0) begin
            chk("post_addr", hs_addr[0], 32'h4);
            chk("post_data", hs_data[0], 32'h1234_5678);
        end
        chk_tx("post", 40'h06, 1);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/uart_dbus_master.md
Name: uart_dbus_master

Overview:
- Host-side debug bridge that acts as a dBus initiator, driving the same cmd/rsp interface the VexRiscv core drives into the memory/IO decode.
- Host frames arrive as bytes from a uart_lite RX port. The block issues word reads and writes on dBus and returns the results through the uart_lite TX port.
- It sits beside the core behind a dBus arbiter, giving the host peek/poke access to RAM and the IO register space without firmware involvement.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- WL, 32, dBus address and data width in bits; must be a multiple of 8.
- BYTE_TIMEOUT_CYCLES, 1000000, maximum idle cycles between frame bytes before the frame is dropped.
- RSP_TIMEOUT_CYCLES, 1024, maximum cycles to wait for dbus_rsp_ready on a read.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe from uart_lite: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_rdy  in  1  uart_lite transmitter idle.
- tx_vld  out  1  one-cycle byte-send strobe.
- tx_data  out  8  byte to send; valid with tx_vld.
- dbus_cmd_valid  out  1  command valid.
- dbus_cmd_ready  in  1  command accepted when high together with valid.
- dbus_cmd_payload_wr  out  1  1 = write, 0 = read.
- dbus_cmd_payload_address  out  WL  byte address.
- dbus_cmd_payload_data  out  WL  write data.
- dbus_cmd_payload_size  out  2  access size; always 2'b10 (word).
- dbus_rsp_ready  in  1  read response strobe.
- dbus_rsp_error  in  1  read error flag; sampled with dbus_rsp_ready.
- dbus_rsp_data  in  WL  read data; sampled with dbus_rsp_ready.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when an rx byte arrives outside a byte-receive state; cleared only by reset.

Behaviour:
- Reset values: tx_vld=0, tx_data=0, dbus_cmd_valid=0, wr=0, address=0, data=0, busy=0, overrun=0; FSM in IDLE; all counters 0.
- Frame format: one command byte, then WL/8 address bytes little-endian, then (write only) WL/8 data bytes little-endian.
  - 0x57 'W' = write.
  - 0x52 'R' = read.
  - Any other command byte: send a single 0x15 (NAK), return to IDLE.
- FSM states:
  - IDLE: wait for rx_valid.
  - ADDR: collect WL/8 bytes.
  - WDATA: collect WL/8 bytes.
  - CMD: hold dbus_cmd_valid and the payload stable until dbus_cmd_ready=1.
  - RSP: wait for the read response.
  - TX: send the queued byte(s).
- Command issue: dbus_cmd_valid rises the cycle after the last frame byte is captured. It deasserts the cycle after the cmd_valid&cmd_ready handshake; the handshake may complete in the first CMD cycle.
- Write completion: writes have no dBus response. After the handshake the TX queue is loaded with 0x06 (ACK).
- Read completion: RSP captures dbus_rsp_data on the first dbus_rsp_ready=1 cycle, which may be the cycle immediately after the handshake. The TX queue is then loaded with the WL/8 data bytes LSB first, followed by a status byte:
  - 0x06 if dbus_rsp_error=0.
  - 0x15 if dbus_rsp_error=1.
- Response timeout: if RSP_TIMEOUT_CYCLES elapse with no dbus_rsp_ready, the queue is loaded with WL/8 bytes of 0x00 followed by 0x15. Any late dbus_rsp_ready arriving outside RSP is ignored.
- TX handshake:
  - Each byte is issued as a one-cycle tx_vld pulse, only in a cycle where tx_rdy=1.
  - The next byte is not issued until tx_rdy has been sampled 0 at least once after the previous pulse and is 1 again.
  - The FSM returns to IDLE after the last queued byte's pulse.
- Inter-byte timeout: in ADDR/WDATA the counter clears on each rx_valid. Reaching BYTE_TIMEOUT_CYCLES drops the frame silently (no reply, no dBus command) and returns to IDLE.
- Byte handling outside receive states: an rx_valid while in CMD, RSP or TX discards the byte and sets overrun. An rx_valid on the same cycle the last frame byte completes a state transition is the captured byte, not an overrun.
- Reset: asynchronous reset mid-frame or mid-command returns to IDLE immediately. dbus_cmd_valid and tx_vld drop asynchronously and the partial frame is lost.
- Widths: the byte counter is $clog2(WL/8)+1 bits; the timeout counters are $clog2(max timeout+1) bits and saturate.

Test Plan:
- Write: rx 57 00 00 00 80 0C 00 00 00, cmd_ready=1 → one dBus write, addr=0x80000000, data=0x0000000C, size=2; tx emits 06.
- Read with backpressure: rx 52 10 00 00 00, cmd_ready held 0 for 5 cycles, then rsp_ready with data=0xDEADBEEF, error=0 → cmd_valid held for 6 cycles with stable payload; tx emits EF BE AD DE 06.
- Read error: rx 52 00 00 00 40, rsp_error=1, data=0x12345678 → tx emits 78 56 34 12 15.
- Bad command and response timeout: rx 0x41 → tx emits 15, no dBus activity. Read with no rsp_ready for 1024 cycles → tx emits 00 00 00 00 15.
- Inter-byte timeout and overrun: rx 57 01, then silence for BYTE_TIMEOUT_CYCLES → busy=0, no cmd_valid, no tx. An rx byte injected during the TX state → overrun=1 and the reply bytes are unchanged.
- Reset mid-operation: assert reset while cmd_valid=1 → cmd_valid=0 in the same cycle, busy=0. A subsequent full write frame completes normally.
